// File: rtl/data_memory_pkg.sv
// Shared funct3 codes, FSM state type and load formatting for the data memory.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Selects the addressed byte/half of a stored word and extends it to 32 bits.
  function automatic logic [31:0] fmt_load(input logic [31:0] word,
                                           input logic [2:0]  funct3,
                                           input logic [1:0]  offset);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*offset +: 8];
    h = offset[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    fmt_load = {{24{b[7]}}, b};
      F3_BU:   fmt_load = {24'd0, b};
      F3_H:    fmt_load = {{16{h[15]}}, h};
      F3_HU:   fmt_load = {16'd0, h};
      F3_W:    fmt_load = word;
      default: fmt_load = 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bundle between the core (master) and the data memory (slave).
interface data_memory_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_fault
  );
endinterface

// File: rtl/data_memory_byte_bank.sv
// One byte lane of the data array: synchronous write, registered read (1 cycle).
module byte_bank #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdat,
  output logic [7:0]    o_rdat
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdat;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdat;
    r_rdat <= r_mem[i_addr];
  end

  assign o_rdat = r_rdat;

endmodule

// File: rtl/data_memory.sv
// Byte-addressed RV32I data memory with valid/ready request and one-cycle response strobe.
// Response WAIT_STATES+2 cycles after acceptance; req_ready stays low until the response cycle ends.
module data_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int WAIT_STATES = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  data_memory_if.slave bus
);

  localparam int         WAW       = ADDR_WIDTH - 2;
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                r_state;
  logic [3:0]            r_cnt;
  logic                  r_write;
  logic                  r_fault;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;

  logic        w_accept;
  logic        w_fault;
  logic        w_range_bad;
  logic        w_f3_bad;
  logic        w_size_bad;
  logic [3:0]  w_lane_en;
  logic [31:0] w_wword;
  logic [31:0] w_rword;

  assign bus.req_ready = (r_state == IDLE);
  assign w_accept      = bus.req_valid && bus.req_ready;

  always_comb begin
    w_range_bad = (bus.req_addr >> ADDR_WIDTH) != 32'd0;
    if (bus.req_write)
      w_f3_bad = !(bus.req_funct3 inside {F3_B, F3_H, F3_W});
    else
      w_f3_bad = !(bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    case (bus.req_funct3)
      F3_H, F3_HU: w_size_bad = bus.req_addr[0];
      F3_W:        w_size_bad = |bus.req_addr[1:0];
      default:     w_size_bad = 1'b0;
    endcase
    w_fault = w_range_bad | w_f3_bad | w_size_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_write  <= 1'b0;
      r_fault  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_write  <= bus.req_write;
            r_funct3 <= bus.req_funct3;
            r_addr   <= bus.req_addr[ADDR_WIDTH-1:0];
            r_wdata  <= bus.req_wdata;
            r_fault  <= w_fault;
            r_cnt    <= WAIT_LOAD;
            r_state  <= (WAIT_STATES > 0) ? WAIT : ACCESS;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) r_state <= ACCESS;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ACCESS:  r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Sub-word stores replicate the data across lanes; the lane enables pick the live ones.
  always_comb begin
    w_lane_en = 4'b0000;
    w_wword   = r_wdata;
    case (r_funct3)
      F3_B: begin
        w_lane_en = 4'b0001 << r_addr[1:0];
        w_wword   = {4{r_wdata[7:0]}};
      end
      F3_H: begin
        w_lane_en = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wword   = {2{r_wdata[15:0]}};
      end
      F3_W:    w_lane_en = 4'b1111;
      default: w_lane_en = 4'b0000;
    endcase
    if (r_state != ACCESS || !r_write || r_fault) w_lane_en = 4'b0000;
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    byte_bank #(.AW(WAW)) u_bank (
      .clk    (clk),
      .i_we   (w_lane_en[g]),
      .i_addr (r_addr[ADDR_WIDTH-1:2]),
      .i_wdat (w_wword[8*g +: 8]),
      .o_rdat (w_rword[8*g +: 8])
    );
  end

  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_fault = (r_state == RESP) && r_fault;
  assign bus.resp_rdata = (r_state == RESP && !r_write && !r_fault)
                          ? fmt_load(w_rword, r_funct3, r_addr[1:0]) : 32'd0;

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: byte-array reference model with per-cycle compare, plus literal vectors.
module tb_data_memory;
  import mem_pkg::*;

  localparam int AW  = 11;
  localparam int WS  = 2;
  localparam int WS3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst3_n;

  data_memory_if bus();
  data_memory_if bus3();

  data_memory #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  data_memory #(.ADDR_WIDTH(AW), .WAIT_STATES(WS3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (bus3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // ---------------- reference model (byte array, one request at a time) ----------------
  logic [7:0]  m_mem [0:(1<<AW)-1];
  int          m_edge       = 0;
  int          m_busy_until = -1;
  int          m_resp_at    = -1;
  logic [31:0] m_rdata      = 32'd0;
  logic        m_fault      = 1'b0;

  task automatic model_access(input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
    int          sz;
    bit          sgn;
    bit          bad;
    logic [31:0] v;
    sz  = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    sgn = (f3 < 3'd4);
    bad = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5);
    if (a >= (32'd1 << AW)) bad = 1;
    if ((a % sz) != 0) bad = 1;
    m_rdata = 32'd0;
    m_fault = bad;
    if (!bad && wr) begin
      for (int i = 0; i < sz; i++) m_mem[a + i] = 8'(wd >> (8 * i));
    end else if (!bad) begin
      v = 32'd0;
      for (int i = 0; i < sz; i++) v = v | (32'(m_mem[a + i]) << (8 * i));
      if (sgn && sz < 4 && v[8*sz-1]) v = v | ~((32'd1 << (8 * sz)) - 32'd1);
      m_rdata = v;
    end
  endtask

  // Period numbering: period p follows the p-th rising edge after reset release.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.req_valid && m_edge > m_busy_until) begin
        model_access(bus.req_write, bus.req_funct3, bus.req_addr, bus.req_wdata);
        m_busy_until = m_edge + WS + 2;
        m_resp_at    = m_edge + WS + 2;
      end
      m_edge++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_ready", 32'(bus.req_ready), 32'(m_edge > m_busy_until));
      check("model_resp_valid", 32'(bus.resp_valid), 32'(m_edge == m_resp_at));
      if (m_edge == m_resp_at) begin
        check("model_rdata", bus.resp_rdata, m_rdata);
        check("model_fault", 32'(bus.resp_fault), 32'(m_fault));
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic req(input string name, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_f);
    int t;
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    t = 0;
    while (!bus.req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) timeout({name, "_accept"});
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    t = 0;
    while (!bus.resp_valid && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) timeout({name, "_resp"});
    check({name, "_rdata"}, bus.resp_rdata, exp_rd);
    check({name, "_fault"}, 32'(bus.resp_fault), 32'(exp_f));
    @(posedge clk); #1;
  endtask

  task automatic req3(input string name, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int lat);
    int t;
    bus3.req_valid  = 1'b1;
    bus3.req_write  = wr;
    bus3.req_funct3 = f3;
    bus3.req_addr   = a;
    bus3.req_wdata  = wd;
    t = 0;
    while (!bus3.req_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) timeout({name, "_accept"});
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    lat = 1;
    while (!bus3.resp_valid && lat < 60) begin @(posedge clk); #1; lat++; end
    if (lat >= 60) timeout({name, "_resp"});
    rd = bus3.resp_rdata;
    @(posedge clk); #1;
  endtask

  logic        rdy_log [0:16];
  logic        rv_log  [0:16];
  logic [31:0] rd3;
  int          lat3;
  int          t3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rst3_n = 1'b0;
    bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_funct3 = 3'd0;
    bus.req_addr  = 32'd0; bus.req_wdata = 32'd0;
    bus3.req_valid = 1'b0;  bus3.req_write = 1'b0;  bus3.req_funct3 = 3'd0;
    bus3.req_addr  = 32'd0; bus3.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready",      32'(bus.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata,      32'd0);
    check("rst_resp_fault", 32'(bus.resp_fault), 32'd0);
    check("rst3_ready",     32'(bus3.req_ready), 32'd1);
    rst_n  = 1'b1;
    rst3_n = 1'b1;

    // Store/load formatting
    req("sw_10",    1, F3_W,  32'h010, 32'hDEADBEEF, 32'h00000000, 0);
    req("lw_10",    0, F3_W,  32'h010, 32'h0,        32'hDEADBEEF, 0);
    req("sb_11",    1, F3_B,  32'h011, 32'hAABBCC55, 32'h00000000, 0);
    req("lw_10b",   0, F3_W,  32'h010, 32'h0,        32'hDEAD55EF, 0);
    req("lb_13",    0, F3_B,  32'h013, 32'h0,        32'hFFFFFFDE, 0);
    req("lbu_13",   0, F3_BU, 32'h013, 32'h0,        32'h000000DE, 0);
    req("lb_10",    0, F3_B,  32'h010, 32'h0,        32'hFFFFFFEF, 0);
    req("lh_10",    0, F3_H,  32'h010, 32'h0,        32'h000055EF, 0);
    req("sh_12",    1, F3_H,  32'h012, 32'h12348001, 32'h00000000, 0);
    req("lh_12",    0, F3_H,  32'h012, 32'h0,        32'hFFFF8001, 0);
    req("lhu_12",   0, F3_HU, 32'h012, 32'h0,        32'h00008001, 0);
    req("lh_13",    0, F3_H,  32'h013, 32'h0,        32'h00000000, 1);
    req("lw_10c",   0, F3_W,  32'h010, 32'h0,        32'h800155EF, 0);
    // Faults
    req("sw_0",     1, F3_W,  32'h000, 32'h11223344, 32'h00000000, 0);
    req("sw_800",   1, F3_W,  32'h800, 32'h99999999, 32'h00000000, 1);
    req("lw_0",     0, F3_W,  32'h000, 32'h0,        32'h11223344, 0);
    req("sw_hi",    1, F3_W,  32'h80000000, 32'h77777777, 32'h00000000, 1);
    req("st_f3_4",  1, 3'd4,  32'h000, 32'hFFFFFFFF, 32'h00000000, 1);
    req("ld_f3_3",  0, 3'd3,  32'h000, 32'h0,        32'h00000000, 1);
    req("ld_f3_7",  0, 3'd7,  32'h000, 32'h0,        32'h00000000, 1);
    req("sw_12mis", 1, F3_W,  32'h012, 32'h0BADF00D, 32'h00000000, 1);
    req("lw_10d",   0, F3_W,  32'h010, 32'h0,        32'h800155EF, 0);
    req("lw_0b",    0, F3_W,  32'h000, 32'h0,        32'h11223344, 0);

    // Latency with WS=2: valid held through the busy window, accepted once
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = F3_W;
    bus.req_addr = 32'h010; bus.req_wdata = 32'h0;
    for (int k = 0; k <= 8; k++) begin
      rdy_log[k] = bus.req_ready;
      rv_log[k]  = bus.resp_valid;
      if (k == 4) bus.req_valid = 1'b0;
      @(posedge clk); #1;
    end
    for (int k = 0; k <= 8; k++) begin
      check($sformatf("lat_ready_c%0d", k), 32'(rdy_log[k]), 32'(k == 0 || k >= 5));
      check($sformatf("lat_rvalid_c%0d", k), 32'(rv_log[k]), 32'(k == 4));
    end

    // Back-to-back loads at the maximum rate: responses every WS+3 cycles
    bus.req_valid = 1'b1; bus.req_funct3 = F3_LW_CODE();
    for (int k = 0; k <= 16; k++) begin
      rv_log[k] = bus.resp_valid;
      if (k == 11) bus.req_valid = 1'b0;
      @(posedge clk); #1;
    end
    for (int k = 0; k <= 16; k++)
      check($sformatf("b2b_rvalid_c%0d", k), 32'(rv_log[k]), 32'(k == 4 || k == 9 || k == 14));

    // Reset mid-operation on the WS=3 instance
    req3("d3_sw_old", 1, F3_W, 32'h020, 32'hCAFEF00D, rd3, lat3);
    check("d3_latency", 32'(lat3), 32'd5);
    check("d3_sw_rdata", rd3, 32'd0);

    bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_funct3 = F3_W;
    bus3.req_addr = 32'h020;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    t3 = 0;
    while (!bus3.resp_valid && t3 < 20) begin @(posedge clk); #1; t3++; end
    if (t3 >= 20) timeout("d3_resp_before_reset");
    check("d3_resp_rdata_pre", bus3.resp_rdata, 32'hCAFEF00D);
    rst3_n = 1'b0;
    #1;
    check("d3_rst_resp_valid", 32'(bus3.resp_valid), 32'd0);
    check("d3_rst_ready",      32'(bus3.req_ready),  32'd1);
    @(posedge clk); #1;
    rst3_n = 1'b1;

    bus3.req_valid = 1'b1; bus3.req_write = 1'b1; bus3.req_funct3 = F3_W;
    bus3.req_addr = 32'h020; bus3.req_wdata = 32'h12345678;
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    check("d3_busy_ready", 32'(bus3.req_ready), 32'd0);
    @(posedge clk); #1;
    rst3_n = 1'b0;
    #1;
    check("d3_wait_rst_rvalid", 32'(bus3.resp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst3_n = 1'b1;
    check("d3_after_rst_ready", 32'(bus3.req_ready), 32'd1);
    repeat (6) begin
      check("d3_no_stray_resp", 32'(bus3.resp_valid), 32'd0);
      @(posedge clk); #1;
    end
    req3("d3_lw_old", 0, F3_W, 32'h020, 32'h0, rd3, lat3);
    check("d3_lw_old_rdata", rd3, 32'hCAFEF00D);

    repeat (4) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  function automatic logic [2:0] F3_LW_CODE();
    return F3_W;
  endfunction

endmodule
